// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit stage. Accepts a parallel word on a valid/ready
//               handshake and shifts it out LSB-first as start bit, data
//               bits, optional even-parity bit and stop bit.
//               Optional feature macro: UART_TX_PARITY_EN (parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int WORD_SIZE       = 8,
    parameter int WORD_SIZE_WIDTH = 4,
    parameter int CLKS_PER_BIT    = 434,
    parameter int BAUD_CNT_WIDTH  = 9
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic [WORD_SIZE-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_serial_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_STOP   = 3'd4;

    localparam logic [BAUD_CNT_WIDTH-1:0]  c_BAUD_LAST = BAUD_CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [WORD_SIZE_WIDTH-1:0] c_BIT_LAST  = WORD_SIZE_WIDTH'(WORD_SIZE - 1);

    logic [2:0]                 state_q,   state_d;
    logic [BAUD_CNT_WIDTH-1:0]  baud_q,    baud_d;
    logic [WORD_SIZE_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [WORD_SIZE-1:0]       shift_q,   shift_d;
    logic                       serial_q,  serial_d;
    logic                       done_q,    done_d;
`ifdef UART_TX_PARITY_EN
    logic                       parity_q,  parity_d;
`endif

    logic w_accept;
    logic w_wrap;
    logic w_word_done;

    // Handshake, end-of-bit-period and last-data-bit strobes
    assign w_accept    = (state_q == c_IDLE) && tx_valid_i;
    assign w_wrap      = (baud_q == c_BAUD_LAST);
    assign w_word_done = w_wrap && (bit_cnt_q == c_BIT_LAST);

    // State and datapath registers; reset forces the line high at once
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= c_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state logic: each non-idle state lasts whole bit periods
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (tx_valid_i) state_d = c_START;
            c_START:  if (w_wrap) state_d = c_DATA;
`ifdef UART_TX_PARITY_EN
            c_DATA:   if (w_word_done) state_d = c_PARITY;
            c_PARITY: if (w_wrap) state_d = c_STOP;
`else
            c_DATA:   if (w_word_done) state_d = c_STOP;
`endif
            c_STOP:   if (w_wrap) state_d = c_IDLE;
            default:  state_d = c_IDLE;
        endcase
    end

    // Counters and shift register: bit counter selects zero on accept, increment per data bit
    always_comb begin
        baud_d    = (state_q == c_IDLE || w_wrap) ? '0 : baud_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (w_accept) begin
            bit_cnt_d = '0;
            shift_d   = tx_data_i;
        end else if (state_q == c_DATA && w_wrap) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
        end
        done_d = (state_q == c_STOP) && w_wrap;
`ifdef UART_TX_PARITY_EN
        parity_d = w_accept ? ^tx_data_i : parity_q;
`endif
    end

    // Outputs: line level is computed from the upcoming state so the register lines up with it
    always_comb begin
        tx_ready_o = (state_q == c_IDLE);
        tx_busy_o  = (state_q != c_IDLE);
        case (state_d)
            c_START:  serial_d = 1'b0;
            c_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            c_PARITY: serial_d = parity_q;
`endif
            default:  serial_d = 1'b1;
        endcase
    end

    assign tx_serial_o = serial_q;
    assign tx_done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Scoreboard bench for uart_tx_serializer (CLKS_PER_BIT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    localparam int W = 8;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAST = (2 + W + P) * C;

    logic       clk      = 1'b0;
    logic       reset_b  = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    wire        tx_ready;
    wire        tx_serial;
    wire        tx_busy;
    wire        tx_done;

    uart_tx_serializer #(
        .WORD_SIZE      (W),
        .WORD_SIZE_WIDTH(4),
        .CLKS_PER_BIT   (C),
        .BAUD_CNT_WIDTH (9)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .tx_serial_o(tx_serial),
        .tx_busy_o  (tx_busy),
        .tx_done_o  (tx_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    // Reference line level k cycles after the handshake edge
    function automatic logic exp_bit(input logic [7:0] w, input int k);
        int slot;
        slot = k / C;
        if (slot == 0) return 1'b0;
        if (slot <= W) return w[slot-1];
        if (P == 1 && slot == W + 1) return ($countones(w) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected word at each handshake and checks every cycle of the frame
    bit         in_frame = 1'b0;
    bit         pending  = 1'b0;
    int         k        = 0;
    logic [7:0] cur      = 8'h00;

    always @(negedge clk) begin
        if (!reset_b) begin
            check("rst_serial", tx_serial, 1'b1);
            check("rst_ready",  tx_ready,  1'b1);
            check("rst_busy",   tx_busy,   1'b0);
            check("rst_done",   tx_done,   1'b0);
            in_frame = 1'b0;
            pending  = 1'b0;
        end else begin
            if (pending) begin
                pending = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL handshake: got accept expected none at t=%0t", $time);
                end else begin
                    cur      = exp_q.pop_front();
                    in_frame = 1'b1;
                    k        = 0;
                end
            end
            if (in_frame) begin
                check($sformatf("line w=%02h k=%0d", cur, k), tx_serial, exp_bit(cur, k));
                if (k == LAST) begin
                    check("end_done",  tx_done,  1'b1);
                    check("end_ready", tx_ready, 1'b1);
                    check("end_busy",  tx_busy,  1'b0);
                    in_frame = 1'b0;
                end else begin
                    check($sformatf("frame_done k=%0d", k),  tx_done,  1'b0);
                    check($sformatf("frame_ready k=%0d", k), tx_ready, 1'b0);
                    check($sformatf("frame_busy k=%0d", k),  tx_busy,  1'b1);
                end
                k++;
            end else begin
                check("idle_serial", tx_serial, 1'b1);
                check("idle_done",   tx_done,   1'b0);
                check("idle_busy",   tx_busy,   1'b0);
                check("idle_ready",  tx_ready,  1'b1);
            end
            if (!in_frame && tx_valid && tx_ready) pending = 1'b1;
        end
    end

    // Bounded wait for tx_ready; optionally scrambles tx_data while the frame runs
    task automatic wait_ready(input bit scramble);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            if (tx_ready) seen = 1'b1;
            else if (scramble && !tx_valid) tx_data = 8'($urandom);
            n++;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got tx_ready=0 expected 1 within 200 cycles at t=%0t", $time);
        end
    endtask

    task automatic send(input logic [7:0] w, input bit hold);
        tx_data  = w;
        tx_valid = 1'b1;
        exp_q.push_back(w);
        wait_ready(1'b0);
        @(posedge clk);
        #1;
        if (!hold) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
    endtask

    task automatic finish_frame();
        wait_ready(1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        send(8'hA5, 1'b0); finish_frame();
        send(8'h07, 1'b0); finish_frame();
        send(8'h03, 1'b0); finish_frame();

        send(8'h55, 1'b1);
        send(8'hAA, 1'b0); finish_frame();

        // Reset in the middle of data bit 3
        send(8'hC3, 1'b0);
        repeat (17) @(posedge clk);
        #2 reset_b = 1'b0;
        #1;
        check("async_rst_serial", tx_serial, 1'b1);
        check("async_rst_busy",   tx_busy,   1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_b = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        send(8'h3C, 1'b0); finish_frame();

        for (int i = 0; i < 8; i++) begin
            bit h;
            h = (i < 7) ? 1'($urandom) : 1'b0;
            send(8'($urandom), h);
            if (!h) finish_frame();
        end

        repeat (5) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d queued words expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit stage in the acoustics comms path: accepts a parallel word over a valid/ready handshake and shifts it out LSB-first as a start bit, data bits, optional parity and a stop bit. It drives the bit-counter stage: it selects zero or increment each bit period and consumes the word-complete flag to leave the data phase. It sits between the packet formatter upstream and the FPGA TX pin downstream.

## Interface
- WORD_SIZE, 8, data bits per frame
- WORD_SIZE_WIDTH, 4, width of the bit counter; must hold WORD_SIZE
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal values are 2 and up
- BAUD_CNT_WIDTH, 9, width of the baud counter; must hold CLKS_PER_BIT-1
- clk  in  1  system clock
- reset_b  in  1  asynchronous, active-low reset
- tx_data  in  WORD_SIZE  word to send; sampled only on handshake
- tx_valid  in  1  upstream has a word
- tx_ready  out  1  block can accept; high only in IDLE
- tx_serial  out  1  serial line, idle high, registered
- tx_busy  out  1  frame in progress (any state other than IDLE)
- tx_done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, START, DATA, PARITY (only when the macro is defined), STOP. Encoding is registered.
- **IDLE:**
  - tx_serial=1, tx_ready=1.
  - On tx_valid & tx_ready at an edge: latch tx_data into the shift register, clear the baud counter, zero the bit counter, go to START.
- **START:** tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:**
  - tx_serial = shift_reg[0].
  - At each baud counter wrap (count reaches CLKS_PER_BIT-1, then returns to 0): shift right by 1 and increment the bit counter.
  - When the bit counter reaches WORD_SIZE: go to PARITY or STOP.
- **PARITY:** tx_serial = XOR of the latched word (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- **STOP:** tx_serial=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse tx_done.
- **Handshake rules:**
  - tx_valid while busy is ignored; no acceptance and no queuing.
  - Changes on tx_data after acceptance have no effect on the frame.
- **Reset behaviour:**
  - Values during reset: state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, all counters 0.
  - Reset asserted mid-frame returns the line high immediately and discards the frame; no tx_done is produced.

## Timing
- Let E0 be the handshake edge and C = CLKS_PER_BIT.
- After E0: tx_serial=0, tx_busy=1, tx_ready=0.
- Data bit i is driven from E0+(1+i)·C for C cycles.
- Parity (when enabled) is driven from E0+(1+WORD_SIZE)·C.
- The stop bit starts at E0+(1+WORD_SIZE+P)·C, where P is 1 with parity and 0 without.
- At E0+(2+WORD_SIZE+P)·C:
  - state=IDLE, tx_ready=1, tx_busy=0;
  - tx_done=1 for exactly one cycle.
- Back-to-back frames: the earliest next handshake edge is one cycle after tx_ready rises. The stop bit is therefore at least C+1 cycles; there is no other idle gap.
- Latency from handshake to the start bit on the line: 1 clk.

## Configuration
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state is compiled in and an even-parity bit follows the data. Frame length is WORD_SIZE+3 bits.
- Undefined: DATA goes directly to STOP. Frame length is WORD_SIZE+2 bits and no parity logic is present.

## Test plan
All scenarios use CLKS_PER_BIT=4 and WORD_SIZE=8.
- Reset release, then tx_valid=0 for 20 cycles -> tx_serial=1, tx_ready=1, tx_busy=0 and tx_done=0 throughout.
- Send 0xA5 with no parity -> line reads 0, then 1,0,1,0,0,1,0,1, then 1. Each bit lasts 4 clks. tx_done pulses at E0+40 and lasts 1 cycle.
- With UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1 and tx_done at E0+44. Send 0x03 -> parity bit=0.
- tx_valid held high with 0x55 then 0xAA -> two frames. Stop bit is 5 clks between them; the second start bit begins 1 clk after tx_ready rises. tx_data toggles mid-frame have no effect.
- reset_b pulsed low during data bit 3 -> tx_serial goes to 1 asynchronously and no tx_done is seen. After release, a new send of 0x3C completes correctly.
